// File: rtl/interval_meter_pkg.sv
// Shared types and helpers for the interval meter and its output stage.
package interval_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meas_state_e;

  // Largest count a w-bit interval counter can hold (valid for w < 32).
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/interval_meter_if.sv
// Event input / result output bundle for interval_meter; master is the meter side.
interface interval_meter_if #(
  parameter int W = 8
);
  logic         enable;
  logic         srst;
  logic         event_i;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_ovf;
  logic         overrun;

  modport master (
    input  enable, srst, event_i, m_ready,
    output m_valid, m_data, m_ovf, overrun
  );

  modport slave (
    output enable, srst, event_i, m_ready,
    input  m_valid, m_data, m_ovf, overrun
  );
endinterface

// File: rtl/meas_out_reg.sv
// Single-entry valid/ready result register: a new result arriving while full is
// dropped and latches a sticky overrun flag; a same-cycle drain and load has no bubble.
module meas_out_reg #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          srst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          overrun
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          overrun_q, overrun_d;
  logic          load;

  always_comb begin
    load      = in_valid && (!valid_q || out_ready);
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    if (srst) begin
      valid_d   = 1'b0;
      data_d    = '0;
      overrun_d = 1'b0;
    end else begin
      if (load) begin
        valid_d = 1'b1;
        data_d  = in_data;
      end else if (out_ready) begin
        valid_d = 1'b0;
      end
      if (in_valid && valid_q && !out_ready) overrun_d = 1'b1;
    end
  end

  // NOTE: the data register is reset too, because the held value is visible on the
  // output port and must read as zero out of reset, not just be ignored while invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/interval_meter.sv
// Measures enabled-cycle spacing between event pulses and reports period-1,
// saturating at the counter limit, through a valid/ready result register.
module interval_meter
  import interval_meter_pkg::*;
#(
  parameter int W        = 8,
  parameter bit SAT_FLAG = 1'b1
) (
  input logic            clk,
  input logic            rst,
  interval_meter_if.master bus
);

  typedef struct packed {
    logic         ovf;
    logic [W-1:0] data;
  } result_t;

  localparam logic [W-1:0] CNT_MAX = W'(cnt_max(W));

  meas_state_e  state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_pend_q, ovf_pend_d;
  logic         res_valid;
  result_t      res;
  result_t      held;

  // NOTE: every output of this block gets a default before the case, so no path
  // through it can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    res_valid  = 1'b0;
    if (bus.srst) begin
      state_d    = IDLE;
      cnt_d      = '0;
      ovf_pend_d = 1'b0;
    end else if (bus.enable) begin
      case (state_q)
        IDLE: begin
          if (bus.event_i) begin
            state_d    = MEASURE;
            cnt_d      = '0;
            ovf_pend_d = 1'b0;
          end
        end
        MEASURE: begin
          if (bus.event_i) begin
            res_valid  = 1'b1;
            cnt_d      = '0;
            ovf_pend_d = 1'b0;
          end else if (cnt_q == CNT_MAX) begin
            ovf_pend_d = SAT_FLAG;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
    end
  end

  assign res = '{ovf: ovf_pend_q, data: cnt_q};

  meas_out_reg #(
    .DW($bits(result_t))
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .srst     (bus.srst),
    .in_valid (res_valid),
    .in_data  (res),
    .out_ready(bus.m_ready),
    .out_valid(bus.m_valid),
    .out_data (held),
    .overrun  (bus.overrun)
  );

  assign bus.m_data = held.data;
  assign bus.m_ovf  = held.ovf & SAT_FLAG;

endmodule
